sdio_data_xfer_ctrl: RTL
========================

SDIO_DATA_XFER_CTRL -- requirements
Module: sdio_data_xfer_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, idle clk cycles between consecutive blocks (range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have i_start  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
REQ-005 SHALL have i_abort  in  1  level; cancels a transfer in progress.
REQ-006 SHALL have i_write_flag  in  1  1 = host-to-card, 0 = card-to-host; latched on start.
REQ-007 SHALL have i_block_mode  in  1  1 = block transfer, 0 = byte transfer; latched on start.
REQ-008 SHALL have i_block_size  in  12  block length in bytes, legal 1..2048; latched on start.
REQ-009 SHALL have i_count  in  9  blocks in block mode (0 = infinite), bytes in byte mode (0 = 512); latched on start.
REQ-010 SHALL have o_phy_activate, o_phy_write_flag (1 each) and o_phy_data_count (13) out, driving the data PHY.
REQ-011 SHALL have i_phy_finished and i_phy_crc_good (1 each) in, from the data PHY.
REQ-012 SHALL have o_busy 1, o_done 1 (pulse), o_error 1, o_aborted 1 and o_blocks_done 9 out (status).
REQ-013 SHALL have o_crc_status_stb 1 and o_crc_status 3 out, the CRC status token request for write blocks.

Function
REQ-014 States SHALL be IDLE, ACTIVATE, WAIT_FIN, RELEASE, STATUS, GAP and DONE.
REQ-015 IDLE + i_start SHALL latch all config inputs, clear o_blocks_done/o_error/o_aborted, and go to ACTIVATE next cycle; o_busy = 1 in every state except IDLE.
REQ-016 Block mode with i_block_size = 0 or > 2048 SHALL go straight to DONE with o_error = 1 and never assert o_phy_activate.
REQ-017 In ACTIVATE, o_phy_data_count SHALL be the latched block size (block mode) or the latched count with 0 mapped to 512 (byte mode); o_phy_activate goes to 1 and the state moves to WAIT_FIN.
REQ-018 o_phy_activate SHALL stay 1 throughout WAIT_FIN.
REQ-019 When i_phy_finished = 1 in WAIT_FIN, the block SHALL capture i_phy_crc_good, drop o_phy_activate and go to RELEASE.
REQ-020 RELEASE SHALL wait for i_phy_finished = 0, then go to STATUS.
REQ-021 STATUS SHALL increment o_blocks_done (9-bit, wraps at 511 in infinite mode).
REQ-022 If the transfer is a write, STATUS SHALL also pulse o_crc_status_stb for one cycle with o_crc_status = 3'b010 (crc good) or 3'b101 (crc bad).
REQ-023 A write crc-bad SHALL set o_error and go to DONE; read transfers SHALL ignore i_phy_crc_good.
REQ-024 After STATUS, the block SHALL go to GAP when more blocks remain (block mode with blocks_done < count, or count = 0), otherwise to DONE; byte mode is always a single pass.
REQ-025 GAP SHALL count GAP_CYCLES cycles, then go to ACTIVATE.
REQ-026 DONE SHALL pulse o_done for exactly one cycle and return to IDLE; o_error, o_aborted and o_blocks_done hold until the next start.
REQ-027 i_abort in any non-IDLE state SHALL deassert o_phy_activate the next cycle, set o_aborted and go to DONE, taking priority over every other transition.
REQ-028 i_abort in IDLE SHALL be ignored, as SHALL i_start while busy.
REQ-029 An abort on the same cycle as i_phy_finished SHALL NOT count the block and SHALL NOT emit a crc status strobe.
REQ-030 o_phy_write_flag SHALL equal the latched i_write_flag and hold stable while o_busy = 1.

Reset
REQ-031 While rst = 0, the state SHALL be IDLE and all outputs 0, except o_crc_status = 3'b000 and o_phy_data_count = 0.
REQ-032 Reset asserted mid-transfer SHALL drop o_phy_activate immediately (asynchronously), with no o_done pulse.

Structure
REQ-033 State encodings, the token constants 3'b010/3'b101 and MAX_BLOCK_SIZE = 2048 SHALL live in the shared sdio_defines package.
REQ-034 The GAP counter SHALL be inline; a single optional sub-module sdio_xfer_gap_timer is permitted.

Verification
REQ-035 Byte write, count = 16, PHY crc good -> one activate with data_count 16, status 010, o_done, blocks_done = 1.
REQ-036 Block read, size 512, count 3 -> three activates separated by >= 2 idle cycles, blocks_done = 3, o_error = 0.
REQ-037 Block write, count 4, crc bad on block 2 -> status 101, stop after 2 blocks, o_error = 1.
REQ-038 Block mode, count 0, abort after 5 blocks -> o_aborted = 1, blocks_done = 5, activate low the next cycle.
REQ-039 Byte mode, count 0 -> data_count 512; block_size 0 in block mode -> immediate o_error with no activate.
REQ-040 Reset asserted during WAIT_FIN -> activate drops without waiting for clk, state IDLE, no o_done.

Source files
------------

// File: rtl/sdio_data_xfer_ctrl_pkg.sv
// Shared definitions for the SDIO data transfer controller: FSM state
// encoding, CRC status token values and block size limits.
package sdio_defines;

    localparam int MAX_BLOCK_SIZE = 2048;
    localparam int BYTE_COUNT_ZERO_LEN = 512;

    // CRC status token presented for each completed write block
    localparam logic [2:0] CRC_TOKEN_GOOD = 3'b010;
    localparam logic [2:0] CRC_TOKEN_BAD  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVATE,
        ST_WAIT_FIN,
        ST_RELEASE,
        ST_STATUS,
        ST_GAP,
        ST_DONE
    } xfer_state_t;

    // A block length is usable when it is non-zero and no larger than the
    // largest block the card can accept.
    function automatic logic block_size_ok(input logic [11:0] size);
        return (size != 12'd0) && (size <= 12'(MAX_BLOCK_SIZE));
    endfunction

    // Number of bytes the PHY moves per pass: the block length in block
    // mode, the byte count in byte mode with zero meaning a full 512 bytes.
    function automatic logic [12:0] phy_count(input logic        block_mode,
                                              input logic [11:0] size,
                                              input logic [8:0]  count);
        if (block_mode)
            return {1'b0, size};
        else if (count == 9'd0)
            return 13'(BYTE_COUNT_ZERO_LEN);
        else
            return {4'b0000, count};
    endfunction

endpackage

// File: rtl/sdio_data_xfer_ctrl_if.sv
// Host control, status and data PHY handshake signals of the SDIO data
// transfer controller. The controller uses the slave view; whatever drives
// the transfer requests and models the PHY uses the master view.
interface sdio_data_xfer_ctrl_if;

    // Transfer request and configuration
    logic        i_start;
    logic        i_abort;
    logic        i_write_flag;
    logic        i_block_mode;
    logic [11:0] i_block_size;
    logic [8:0]  i_count;

    // Data PHY handshake
    logic        o_phy_activate;
    logic        o_phy_write_flag;
    logic [12:0] o_phy_data_count;
    logic        i_phy_finished;
    logic        i_phy_crc_good;

    // Status
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic        o_aborted;
    logic [8:0]  o_blocks_done;
    logic        o_crc_status_stb;
    logic [2:0]  o_crc_status;

    modport slave (
        input  i_start, i_abort, i_write_flag, i_block_mode, i_block_size, i_count,
        input  i_phy_finished, i_phy_crc_good,
        output o_phy_activate, o_phy_write_flag, o_phy_data_count,
        output o_busy, o_done, o_error, o_aborted, o_blocks_done,
        output o_crc_status_stb, o_crc_status
    );

    modport master (
        output i_start, i_abort, i_write_flag, i_block_mode, i_block_size, i_count,
        output i_phy_finished, i_phy_crc_good,
        input  o_phy_activate, o_phy_write_flag, o_phy_data_count,
        input  o_busy, o_done, o_error, o_aborted, o_blocks_done,
        input  o_crc_status_stb, o_crc_status
    );

endinterface

// File: rtl/sdio_data_xfer_ctrl.sv
// SDIO data transfer controller. Sequences one or more PHY passes (blocks
// or a single byte transfer), spaces consecutive blocks by GAP_CYCLES idle
// cycles, issues CRC status tokens for write blocks and reports completion,
// CRC failure and abort. All outputs are registered.
module sdio_data_xfer_ctrl
    import sdio_defines::*;
#(
    parameter int GAP_CYCLES = 2   // idle cycles between blocks, 1..15
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active low
    sdio_data_xfer_ctrl_if.slave bus
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    xfer_state_t state, state_n;

    // Configuration latched on start
    logic        write_q;
    logic        block_mode_q;
    logic [8:0]  count_q;
    logic [12:0] data_count_q;

    // Per-block and status registers
    logic        crc_good_q;
    logic [3:0]  gap_q;
    logic [8:0]  blocks_done_q;
    logic        error_q;
    logic        aborted_q;
    logic        busy_q;
    logic        done_q;
    logic        act_q;
    logic        stb_q;
    logic [2:0]  token_q;

    // Decoded transition events
    logic        start_go;
    logic        start_bad;
    logic        capture_crc;
    logic        crc_fail;
    logic        abort_go;
    logic        enter_gap;
    logic        enter_status;
    logic        more_blocks;

    // State register
    // NOTE: the reset branch is written with the async edge in the
    // sensitivity list so the state (and the PHY activate it implies) falls
    // the instant rst goes low, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next-state selection and the transition events that steer the datapath
    always_comb begin
        // NOTE: every signal this block drives receives a value before the
        // case statement, so no path can leave one unassigned and infer a latch.
        state_n      = state;
        start_go     = 1'b0;
        start_bad    = 1'b0;
        capture_crc  = 1'b0;
        crc_fail     = 1'b0;
        abort_go     = 1'b0;
        enter_gap    = 1'b0;
        more_blocks  = block_mode_q && ((count_q == 9'd0) || (blocks_done_q < count_q));

        // Abort beats every other transition once a transfer is running; in
        // DONE the transfer is already ending, so there is nothing to cancel.
        if (state != ST_IDLE && state != ST_DONE && bus.i_abort) begin
            state_n  = ST_DONE;
            abort_go = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        start_go = 1'b1;
                        if (bus.i_block_mode && !block_size_ok(bus.i_block_size)) begin
                            start_bad = 1'b1;
                            state_n   = ST_DONE;
                        end else begin
                            state_n   = ST_ACTIVATE;
                        end
                    end
                end
                ST_ACTIVATE: state_n = ST_WAIT_FIN;
                ST_WAIT_FIN: begin
                    if (bus.i_phy_finished) begin
                        capture_crc = 1'b1;
                        state_n     = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.i_phy_finished)
                        state_n = ST_STATUS;
                end
                ST_STATUS: begin
                    if (write_q && !crc_good_q) begin
                        crc_fail = 1'b1;
                        state_n  = ST_DONE;
                    end else if (more_blocks) begin
                        enter_gap = 1'b1;
                        state_n   = ST_GAP;
                    end else begin
                        state_n   = ST_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 4'd0)
                        state_n = ST_ACTIVATE;
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // A block is counted only when RELEASE completes normally; an abort
    // diverts to DONE first, so an aborted block is never counted.
    assign enter_status = (state == ST_RELEASE) && (state_n == ST_STATUS);

    // Configuration latches, block counter, status flags and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q       <= 1'b0;
            block_mode_q  <= 1'b0;
            count_q       <= '0;
            data_count_q  <= '0;
            crc_good_q    <= 1'b0;
            gap_q         <= '0;
            blocks_done_q <= '0;
            error_q       <= 1'b0;
            aborted_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            act_q         <= 1'b0;
            stb_q         <= 1'b0;
            token_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register here sample
            // the pre-edge values, matching the state register above.
            busy_q <= (state_n != ST_IDLE);
            done_q <= (state_n == ST_DONE);
            act_q  <= (state_n == ST_WAIT_FIN);
            stb_q  <= enter_status && write_q;

            if (enter_status && write_q)
                token_q <= crc_good_q ? CRC_TOKEN_GOOD : CRC_TOKEN_BAD;

            if (start_go) begin
                write_q       <= bus.i_write_flag;
                block_mode_q  <= bus.i_block_mode;
                count_q       <= bus.i_count;
                blocks_done_q <= '0;
                error_q       <= start_bad;
                aborted_q     <= 1'b0;
                if (!start_bad)
                    data_count_q <= phy_count(bus.i_block_mode, bus.i_block_size, bus.i_count);
            end

            if (capture_crc)
                crc_good_q <= bus.i_phy_crc_good;

            // Wraps naturally at 511 in infinite mode
            if (enter_status)
                blocks_done_q <= blocks_done_q + 9'd1;

            if (crc_fail)
                error_q <= 1'b1;

            if (abort_go)
                aborted_q <= 1'b1;

            if (enter_gap)
                gap_q <= GAP_LOAD;
            else if (state == ST_GAP && gap_q != 4'd0)
                gap_q <= gap_q - 4'd1;
        end
    end

    assign bus.o_phy_activate   = act_q;
    assign bus.o_phy_write_flag = write_q;
    assign bus.o_phy_data_count = data_count_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_done           = done_q;
    assign bus.o_error          = error_q;
    assign bus.o_aborted        = aborted_q;
    assign bus.o_blocks_done    = blocks_done_q;
    assign bus.o_crc_status_stb = stb_q;
    assign bus.o_crc_status     = token_q;

endmodule
